// File: rtl/bus_arbiter.sv
// Two-requester (CPU/DMA) single-port memory arbiter.
// One access at a time: IDLE -> ACCESS (WAIT_CYC+1 cycles) -> DONE -> IDLE.
// Ties in IDLE are broken round-robin against the last-served requester.
module bus_arbiter #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [12:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [4:0] WAIT_LD = 5'(WAIT_CYC);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;      // last-served requester: 0 CPU, 1 DMA
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        grant;

    // Pick the grantee: sole requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant = 1'b0;
        if (cpu_req && dma_req) begin
            grant = ~last_q;
        end else if (dma_req) begin
            grant = 1'b1;
        end
    end

    // Next-state and datapath updates; everything holds unless a transition says otherwise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ACCESS;
                    owner_d = grant;
                    last_d  = grant;
                    cnt_d   = WAIT_LD;
                    we_d    = grant ? dma_we    : cpu_we;
                    addr_d  = grant ? dma_addr  : cpu_addr;
                    wdata_d = grant ? dma_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                    // Read data is valid only on the last access cycle.
                    if (!we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any access and makes CPU win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= 13'd0;
            wdata_q     <= 8'd0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Outputs decode straight from registers so reset clears them immediately.
    assign mem_cs    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == DONE) && !owner_q;
    assign dma_ack   = (state_q == DONE) &&  owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Three instances (WAIT_CYC 1, 0, 7) share
// the requester inputs; most scenarios observe the WAIT_CYC=1 instance.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [12:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic [7:0]  mem_rdata = '0;

    logic        cpu_ack, dma_ack, mem_cs, mem_we, busy, owner;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata;
    logic [12:0] mem_addr;

    logic        cpu_ack_w0, dma_ack_w0, mem_cs_w0, mem_we_w0, busy_w0, owner_w0;
    logic [7:0]  cpu_rdata_w0, dma_rdata_w0, mem_wdata_w0;
    logic [12:0] mem_addr_w0;

    logic        cpu_ack_w7, dma_ack_w7, mem_cs_w7, mem_we_w7, busy_w7, owner_w7;
    logic [7:0]  cpu_rdata_w7, dma_rdata_w7, mem_wdata_w7;
    logic [12:0] mem_addr_w7;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_CYC(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    bus_arbiter #(.WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_w0), .cpu_rdata(cpu_rdata_w0),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack_w0), .dma_rdata(dma_rdata_w0),
        .mem_cs(mem_cs_w0), .mem_we(mem_we_w0), .mem_addr(mem_addr_w0), .mem_wdata(mem_wdata_w0),
        .mem_rdata(mem_rdata), .busy(busy_w0), .owner(owner_w0)
    );

    bus_arbiter #(.WAIT_CYC(7)) u_dut_w7 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_w7), .cpu_rdata(cpu_rdata_w7),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack_w7), .dma_rdata(dma_rdata_w7),
        .mem_cs(mem_cs_w7), .mem_we(mem_we_w7), .mem_addr(mem_addr_w7), .mem_wdata(mem_wdata_w7),
        .mem_rdata(mem_rdata), .busy(busy_w7), .owner(owner_w7)
    );

    // Pulse reset across two falling edges with requests idle; ends just after a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_cs, mem_we, cpu_ack, dma_ack, busy, owner} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: cs/we/cack/dack/busy/owner=%b required 000000",
                     {mem_cs, mem_we, cpu_ack, dma_ack, busy, owner});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h required all zero",
                     mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, mem_cs} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b cs=%b required 0 0", busy, mem_cs);
        end
        $display("reset: outputs cleared, idle without requests");
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123; cpu_wdata = 8'hEE;
        mem_rdata = 8'h5A;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            n_checks++;
            if (mem_cs !== (n == 1 || n == 2) || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_read_cs c%0d: cs=%b we=%b required cs=%b we=0",
                         n, mem_cs, mem_we, (n == 1 || n == 2));
            end
            n_checks++;
            if (cpu_ack !== (n == 3) || dma_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_read_ack c%0d: cack=%b dack=%b required %b 0",
                         n, cpu_ack, dma_ack, (n == 3));
            end
            n_checks++;
            if (busy !== (n >= 1 && n <= 3)) begin
                n_fail++;
                $display("FAIL cpu_read_busy c%0d: busy=%b required %b", n, busy, (n <= 3));
            end
            if (n == 1) begin
                n_checks++;
                if (mem_addr !== 13'h0123 || owner !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cpu_read_addr: addr=%h owner=%b required 0123 0", mem_addr, owner);
                end
            end
            if (cpu_ack) cpu_req = 1'b0;
        end
        n_checks++;
        if (cpu_rdata !== 8'h5A || dma_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL cpu_read_data: crd=%h drd=%h required 5a 00", cpu_rdata, dma_rdata);
        end
        $display("cpu read 0123 -> %h", cpu_rdata);
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h1FFF; dma_wdata = 8'hC3;
        mem_rdata = 8'h77;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            n_checks++;
            if (mem_cs !== (n == 1 || n == 2) || mem_we !== (n == 1 || n == 2)) begin
                n_fail++;
                $display("FAIL dma_write_strobe c%0d: cs=%b we=%b required %b %b",
                         n, mem_cs, mem_we, (n == 1 || n == 2), (n == 1 || n == 2));
            end
            n_checks++;
            if (dma_ack !== (n == 3) || cpu_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL dma_write_ack c%0d: dack=%b cack=%b required %b 0",
                         n, dma_ack, cpu_ack, (n == 3));
            end
            n_checks++;
            if (mem_addr !== 13'h1FFF || mem_wdata !== 8'hC3 || owner !== 1'b1) begin
                n_fail++;
                $display("FAIL dma_write_bus c%0d: addr=%h wdata=%h owner=%b required 1fff c3 1",
                         n, mem_addr, mem_wdata, owner);
            end
            if (dma_ack) dma_req = 1'b0;
        end
        n_checks++;
        if (cpu_rdata !== 8'h5A || dma_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL dma_write_rdata: crd=%h drd=%h required 5a 00", cpu_rdata, dma_rdata);
        end
        dma_we = 1'b0;
        $display("dma write 1fff <= c3");
    endtask

    task automatic test_round_robin();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0001;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0002;
        mem_rdata = 8'h3C;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_ack !== (n == 3 || n == 11) || dma_ack !== (n == 7 || n == 15)) begin
                n_fail++;
                $display("FAIL rr_ack c%0d: cack=%b dack=%b required %b %b", n, cpu_ack, dma_ack,
                         (n == 3 || n == 11), (n == 7 || n == 15));
            end
            if (n % 4 == 1) begin
                n_checks++;
                if (owner !== 1'((n / 4) % 2) || mem_cs !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_grant c%0d: owner=%b cs=%b required %0d 1",
                             n, owner, mem_cs, (n / 4) % 2);
                end
                $display("round robin grant c%0d -> %s", n, owner ? "DMA" : "CPU");
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic test_wait_cycles();
        int first0, first1, first7, cs7;
        apply_reset();
        first0 = -1; first1 = -1; first7 = -1; cs7 = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (cpu_ack_w0 && first0 < 0) first0 = n;
            if (cpu_ack    && first1 < 0) first1 = n;
            if (cpu_ack_w7 && first7 < 0) first7 = n;
            if (mem_cs_w7 && first7 < 0) cs7++;
        end
        cpu_req = 1'b0;
        n_checks++;
        if (first0 !== 2) begin
            n_fail++;
            $display("FAIL wait0_latency: ack cycle %0d required 2", first0);
        end
        n_checks++;
        if (first1 !== 3) begin
            n_fail++;
            $display("FAIL wait1_latency: ack cycle %0d required 3", first1);
        end
        n_checks++;
        if (first7 !== 9 || cs7 !== 8) begin
            n_fail++;
            $display("FAIL wait7_latency: ack cycle %0d cs cycles %0d required 9 8", first7, cs7);
        end
        $display("wait cycles: ack at %0d/%0d/%0d for WAIT_CYC 0/1/7", first0, first1, first7);
    endtask

    task automatic test_latch_inputs();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cpu_addr = 13'h0020;
                cpu_req  = 1'b0;
            end
            n_checks++;
            if (mem_addr !== 13'h0010 || mem_cs !== (n <= 2) || cpu_ack !== (n == 3)) begin
                n_fail++;
                $display("FAIL latch c%0d: addr=%h cs=%b cack=%b required 0010 %b %b",
                         n, mem_addr, mem_cs, cpu_ack, (n <= 2), (n == 3));
            end
        end
        $display("latched addr held at %h after requester change", mem_addr);
    endtask

    task automatic test_reset_abort();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0042;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 13'h0100;
        mem_rdata = 8'h99;
        @(negedge clk);
        n_checks++;
        if (mem_cs !== 1'b1 || owner !== 1'b0 || mem_addr !== 13'h0042) begin
            n_fail++;
            $display("FAIL abort_grant: cs=%b owner=%b addr=%h required 1 0 0042", mem_cs, owner, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        #1;
        n_checks++;
        if ({mem_cs, mem_we, cpu_ack, dma_ack, busy, owner} !== 6'b0 ||
            {mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 37'd0) begin
            n_fail++;
            $display("FAIL abort_clear: ctrl=%b addr=%h wdata=%h crd=%h drd=%h required all zero",
                     {mem_cs, mem_we, cpu_ack, dma_ack, busy, owner}, mem_addr, mem_wdata,
                     cpu_rdata, dma_rdata);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_noack: cack=%b dack=%b required 0 0", cpu_ack, dma_ack);
            end
        end
        rst = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_checks++;
            if (mem_cs !== (n <= 2) || dma_ack !== (n == 3) || cpu_ack !== 1'b0 || owner !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_dma c%0d: cs=%b dack=%b cack=%b owner=%b required %b %b 0 1",
                         n, mem_cs, dma_ack, cpu_ack, owner, (n <= 2), (n == 3));
            end
            if (dma_ack) dma_req = 1'b0;
        end
        n_checks++;
        if (dma_rdata !== 8'h99 || cpu_rdata !== 8'h00 || mem_addr !== 13'h0100) begin
            n_fail++;
            $display("FAIL abort_data: drd=%h crd=%h addr=%h required 99 00 0100",
                     dma_rdata, cpu_rdata, mem_addr);
        end
        $display("reset abort: pending dma read -> %h", dma_rdata);
    endtask

    initial begin
        #2;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_wait_cycles();
        test_latch_inputs();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: WAIT_CYC, default 1, extra memory-access cycles beyond the first; legal range 0..7.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 Port: cpu_we  input  1  CPU write (1) / read (0).
REQ-006 Port: cpu_addr  input  13  CPU address.
REQ-007 Port: cpu_wdata  input  8  CPU write data.
REQ-008 Port: cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 Port: cpu_rdata  output  8  registered CPU read data.
REQ-010 Port: dma_req / dma_we / dma_addr / dma_wdata  input  1/1/13/8  DMA requester, same semantics as CPU.
REQ-011 Port: dma_ack / dma_rdata  output  1/8  DMA completion pulse and registered read data.
REQ-012 Port: mem_cs / mem_we  output  1/1  memory select and write strobe.
REQ-013 Port: mem_addr / mem_wdata  output  13/8  memory address and write data.
REQ-014 Port: mem_rdata  input  8  memory read data, valid on last ACCESS cycle.
REQ-015 Port: busy / owner  output  1/1  arbiter not IDLE; current/last grantee (0 CPU, 1 DMA).

Function
REQ-016 FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS when any req=1; ACCESS->DONE after WAIT_CYC+1 cycles; DONE->IDLE unconditionally.
REQ-017 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-018 In IDLE with both req high, grant SHALL go to the requester not served last (round-robin); last-served SHALL reset to DMA so CPU wins first tie.
REQ-019 On IDLE->ACCESS edge, owner, we, addr and wdata of grantee SHALL be latched; later requester input changes SHALL not affect the access.
REQ-020 mem_cs SHALL be 1 exactly during ACCESS cycles; mem_we SHALL equal latched we during ACCESS and 0 otherwise.
REQ-021 mem_addr/mem_wdata SHALL show latched values, holding them outside ACCESS.
REQ-022 A 5-bit wait counter SHALL load WAIT_CYC on ACCESS entry and decrement per ACCESS cycle; count 0 is the last ACCESS cycle.
REQ-023 Read: on the last ACCESS edge mem_rdata SHALL be captured into owner's rdata register; other rdata unchanged.
REQ-024 Write: both rdata registers SHALL remain unchanged.
REQ-025 Owner's ack SHALL be 1 only in DONE (one cycle); the other ack SHALL stay 0.
REQ-026 Latency: req sampled in IDLE cycle 0 -> ack in cycle WAIT_CYC+2; back-to-back throughput one access per WAIT_CYC+3 cycles.
REQ-027 Requesters drop req on the edge sampling ack=1; a req still high in IDLE after DONE SHALL be treated as a new request.
REQ-028 req deasserted mid-ACCESS SHALL not abort; access completes and ack still pulses.
REQ-029 Losing requester's req SHALL remain pending, granted on the next IDLE cycle.
REQ-030 busy SHALL be 1 in ACCESS and DONE, 0 in IDLE.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, acks=0, rdata=0, owner=0, busy=0, last-served=DMA.
REQ-032 Reset mid-ACCESS SHALL abort the access with no ack and no rdata update; after release, first edge with req SHALL start a fresh arbitration.

Verification
REQ-033 WAIT_CYC=1, CPU read addr 0x0123, mem_rdata=0x5A -> mem_cs high 2 cycles, cpu_ack in cycle 3, cpu_rdata=0x5A, dma_rdata=0x00.
REQ-034 DMA write addr 0x1FFF data 0xC3 -> mem_we=1 with mem_cs for 2 cycles, dma_ack pulse, rdata unchanged.
REQ-035 Both req high from reset, held continuously -> grant order CPU, DMA, CPU, DMA; acks alternate every 4 cycles.
REQ-036 WAIT_CYC=0 and WAIT_CYC=7 CPU reads -> ack at cycle 2 and 9 respectively.
REQ-037 CPU changes cpu_addr 0x0010->0x0020 and drops req mid-ACCESS -> mem_addr stays 0x0010, cpu_ack still pulses.
REQ-038 rst low during second ACCESS cycle -> all outputs zero at once, no ack; after release, pending DMA req granted normally.
